ctrl_sequencer: RTL and testbench

Registered decode-stage control sequencer for the pipelined core. It sits between the combinational opcode decoder and the ID/EX pipeline register.
- Passes per-instruction control bundles through with one cycle of latency.
- Owns every multi-cycle decode sequence: two-word LDM immediate capture, and parametrised bubble insertion after RET, RTI and INT.
- Supports stall and flush.
- Replaces ad-hoc flush and two-word counters carried in pipeline fields with a single owned state machine.

---
 rtl/ctrl_sequencer.sv | 169 ++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// ctrl_sequencer
//   Registered decode-stage control sequencer. Sits between the combinational
//   opcode decoder and the ID/EX pipeline register. Ordinary instructions pass
//   through with one cycle of latency. The block owns the multi-cycle decode
//   sequences: the two-word LDM (opcode word, then immediate word) and the
//   bubble run that follows RET, RTI and INT.
//
// Ports:
//   clk          core clock
//   rst_n        asynchronous active-low reset
//   instr_valid  fetched word present this cycle
//   opcode       opcode field of the fetched word
//   ctrl_in      control bundle from the combinational decoder
//   stall        hold every register (load-use stall)
//   flush        taken branch/jump from EX; kills any sequence in progress
//   ctrl_out     registered control bundle to ID/EX
//   ctrl_valid   ctrl_out is a real instruction (0 = bubble)
//   imm_phase    current ID/EX entry carries the LDM immediate word
//   pc_hold      fetch must not advance the PC (high while in BUBBLE)
//   bubble_cnt   remaining bubbles
// ---------------------------------------------------------------------------
module ctrl_sequencer #(
    parameter int                 OPC_W       = 5,
    parameter int                 CTRL_W      = 14,
    parameter int                 CNT_W       = 3,
    parameter logic [OPC_W-1:0]   OP_LDM      = 5'h0C,
    parameter logic [OPC_W-1:0]   OP_RET      = 5'h17,
    parameter logic [OPC_W-1:0]   OP_RTI      = 5'h18,
    parameter logic [OPC_W-1:0]   OP_INT      = 5'h1A,
    parameter int                 RET_BUBBLES = 2,
    parameter int                 INT_BUBBLES = 3,
    parameter logic [CTRL_W-1:0]  LDM_CTRL    = 14'b0000011000_0011
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              stall,
    input  logic              flush,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              ctrl_valid,
    output logic              imm_phase,
    output logic              pc_hold,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        ST_DECODE  = 2'b00,
        ST_LDM_IMM = 2'b01,
        ST_BUBBLE  = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  RET_CNT  = CNT_W'(RET_BUBBLES);
    localparam logic [CNT_W-1:0]  INT_CNT  = CNT_W'(INT_BUBBLES);
    localparam logic [CTRL_W-1:0] CTRL_NOP = {CTRL_W{1'b0}};

    state_t state_r;

    // Moore output: fetch is frozen for exactly the bubble cycles.
    assign pc_hold = (state_r == ST_BUBBLE);

    // Sequencer state machine and registered output bundle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_DECODE;
            ctrl_out   <= CTRL_NOP;
            ctrl_valid <= 1'b0;
            imm_phase  <= 1'b0;
            bubble_cnt <= CNT_ZERO;
        end else if (flush) begin
            // Flush wins over stall: a killed sequence must not be held.
            state_r    <= ST_DECODE;
            ctrl_out   <= CTRL_NOP;
            ctrl_valid <= 1'b0;
            imm_phase  <= 1'b0;
            bubble_cnt <= CNT_ZERO;
        end else if (stall) begin
            state_r    <= state_r;
            ctrl_out   <= ctrl_out;
            ctrl_valid <= ctrl_valid;
            imm_phase  <= imm_phase;
            bubble_cnt <= bubble_cnt;
        end else begin
            case (state_r)
                ST_DECODE: begin
                    imm_phase  <= 1'b0;
                    bubble_cnt <= CNT_ZERO;
                    if (!instr_valid) begin
                        state_r    <= ST_DECODE;
                        ctrl_out   <= CTRL_NOP;
                        ctrl_valid <= 1'b0;
                    end else if (opcode == OP_LDM) begin
                        // The opcode word itself issues as a bubble; the
                        // useful work rides on the following immediate word.
                        state_r    <= ST_LDM_IMM;
                        ctrl_out   <= CTRL_NOP;
                        ctrl_valid <= 1'b0;
                    end else if ((opcode == OP_RET) || (opcode == OP_RTI)) begin
                        ctrl_out   <= ctrl_in;
                        ctrl_valid <= 1'b1;
                        if (RET_CNT != CNT_ZERO) begin
                            state_r    <= ST_BUBBLE;
                            bubble_cnt <= RET_CNT;
                        end else begin
                            state_r    <= ST_DECODE;
                        end
                    end else if (opcode == OP_INT) begin
                        ctrl_out   <= ctrl_in;
                        ctrl_valid <= 1'b1;
                        if (INT_CNT != CNT_ZERO) begin
                            state_r    <= ST_BUBBLE;
                            bubble_cnt <= INT_CNT;
                        end else begin
                            state_r    <= ST_DECODE;
                        end
                    end else begin
                        state_r    <= ST_DECODE;
                        ctrl_out   <= ctrl_in;
                        ctrl_valid <= 1'b1;
                    end
                end

                ST_LDM_IMM: begin
                    bubble_cnt <= CNT_ZERO;
                    if (instr_valid) begin
                        // Immediate word: its opcode field is data, never decoded.
                        state_r    <= ST_DECODE;
                        ctrl_out   <= LDM_CTRL;
                        ctrl_valid <= 1'b1;
                        imm_phase  <= 1'b1;
                    end else begin
                        state_r    <= ST_LDM_IMM;
                        ctrl_out   <= CTRL_NOP;
                        ctrl_valid <= 1'b0;
                        imm_phase  <= 1'b0;
                    end
                end

                ST_BUBBLE: begin
                    ctrl_out   <= CTRL_NOP;
                    ctrl_valid <= 1'b0;
                    imm_phase  <= 1'b0;
                    // The <= guard keeps the counter from wrapping even if a
                    // zero count were ever seen here.
                    if (bubble_cnt <= CNT_ONE) begin
                        state_r    <= ST_DECODE;
                        bubble_cnt <= CNT_ZERO;
                    end else begin
                        state_r    <= ST_BUBBLE;
                        bubble_cnt <= bubble_cnt - CNT_ONE;
                    end
                end

                default: begin
                    state_r    <= ST_DECODE;
                    ctrl_out   <= CTRL_NOP;
                    ctrl_valid <= 1'b0;
                    imm_phase  <= 1'b0;
                    bubble_cnt <= CNT_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ctrl_sequencer
//   Self-checking bench for ctrl_sequencer: directed vector table, a reset
//   during a bubble run, and randomized traffic against a counting model.
// ---------------------------------------------------------------------------
module tb_ctrl_sequencer;

    localparam int          OPC_W  = 5;
    localparam int          CTRL_W = 14;
    localparam int          CNT_W  = 3;
    localparam logic [4:0]  OP_LDM = 5'h0C;
    localparam logic [4:0]  OP_RET = 5'h17;
    localparam logic [4:0]  OP_RTI = 5'h18;
    localparam logic [4:0]  OP_INT = 5'h1A;
    localparam int          RET_B  = 2;
    localparam int          INT_B  = 3;
    localparam logic [13:0] LDMC   = 14'h0183;

    logic              clk;
    logic              rst_n;
    logic              instr_valid;
    logic [OPC_W-1:0]  opcode;
    logic [CTRL_W-1:0] ctrl_in;
    logic              stall;
    logic              flush;
    logic [CTRL_W-1:0] ctrl_out;
    logic              ctrl_valid;
    logic              imm_phase;
    logic              pc_hold;
    logic [CNT_W-1:0]  bubble_cnt;

    int total = 0;
    int bad   = 0;

    ctrl_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .ctrl_in     (ctrl_in),
        .stall       (stall),
        .flush       (flush),
        .ctrl_out    (ctrl_out),
        .ctrl_valid  (ctrl_valid),
        .imm_phase   (imm_phase),
        .pc_hold     (pc_hold),
        .bubble_cnt  (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  op;
        logic [13:0] ci;
        logic        st;
        logic        fl;
        logic [13:0] e_out;
        logic        e_val;
        logic        e_imm;
        logic        e_hold;
        logic [2:0]  e_cnt;
    } vec_t;

    task automatic check(input string name, input logic [13:0] e_out, input logic e_val,
                         input logic e_imm, input logic e_hold, input logic [2:0] e_cnt);
        total++;
        if (ctrl_out !== e_out || ctrl_valid !== e_val || imm_phase !== e_imm ||
            pc_hold !== e_hold || bubble_cnt !== e_cnt) begin
            bad++;
            $display("FAIL %s: got out=%h val=%b imm=%b hold=%b cnt=%0d, want out=%h val=%b imm=%b hold=%b cnt=%0d",
                     name, ctrl_out, ctrl_valid, imm_phase, pc_hold, bubble_cnt,
                     e_out, e_val, e_imm, e_hold, e_cnt);
        end
    endtask

    // Drive one cycle of inputs and advance to just after the sampling edge.
    task automatic apply(input logic v, input logic [4:0] op, input logic [13:0] ci,
                         input logic st, input logic fl);
        instr_valid = v;
        opcode      = op;
        ctrl_in     = ci;
        stall       = st;
        flush       = fl;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [30];

    // Model state: remaining bubbles and whether an LDM immediate is expected.
    int          m_bub;
    bit          m_ldm;
    logic [13:0] m_out;
    logic        m_val;
    logic        m_imm;

    initial begin
        // Directed table: outputs expected after the edge that samples the row.
        //          v     op      ci       st    fl    out      val   imm   hold  cnt
        vecs[0]  = '{1'b1, 5'h01, 14'h1A05, 1'b0, 1'b0, 14'h1A05, 1'b1, 1'b0, 1'b0, 3'd0};
        vecs[1]  = '{1'b1, 5'h02, 14'h0123, 1'b0, 1'b0, 14'h0123, 1'b1, 1'b0, 1'b0, 3'd0};
        vecs[2]  = '{1'b1, 5'h03, 14'h3FFF, 1'b0, 1'b0, 14'h3FFF, 1'b1, 1'b0, 1'b0, 3'd0};
        vecs[3]  = '{1'b1, 5'h04, 14'h0001, 1'b0, 1'b0, 14'h0001, 1'b1, 1'b0, 1'b0, 3'd0};
        vecs[4]  = '{1'b0, 5'h05, 14'h2222, 1'b0, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[5]  = '{1'b1, OP_LDM, 14'h3FFF, 1'b0, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[6]  = '{1'b1, OP_RET, 14'h2AAA, 1'b0, 1'b0, LDMC,     1'b1, 1'b1, 1'b0, 3'd0};
        vecs[7]  = '{1'b0, 5'h00, 14'h0000, 1'b0, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[8]  = '{1'b1, OP_RET, 14'h1111, 1'b0, 1'b0, 14'h1111, 1'b1, 1'b0, 1'b1, 3'd2};
        vecs[9]  = '{1'b1, 5'h01, 14'h2222, 1'b0, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b1, 3'd1};
        vecs[10] = '{1'b1, OP_INT, 14'h2223, 1'b0, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[11] = '{1'b1, OP_INT, 14'h0555, 1'b0, 1'b0, 14'h0555, 1'b1, 1'b0, 1'b1, 3'd3};
        vecs[12] = '{1'b1, OP_LDM, 14'h0000, 1'b0, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b1, 3'd2};
        vecs[13] = '{1'b0, 5'h00, 14'h0000, 1'b0, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b1, 3'd1};
        vecs[14] = '{1'b0, 5'h00, 14'h0000, 1'b0, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[15] = '{1'b1, OP_RTI, 14'h0777, 1'b0, 1'b0, 14'h0777, 1'b1, 1'b0, 1'b1, 3'd2};
        vecs[16] = '{1'b1, 5'h01, 14'h1234, 1'b1, 1'b1, 14'h0000, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[17] = '{1'b1, OP_LDM, 14'h0000, 1'b0, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[18] = '{1'b1, 5'h01, 14'h1234, 1'b1, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[19] = '{1'b1, OP_RET, 14'h1234, 1'b1, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[20] = '{1'b0, 5'h01, 14'h1234, 1'b1, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[21] = '{1'b1, 5'h05, 14'h0000, 1'b0, 1'b0, LDMC,     1'b1, 1'b1, 1'b0, 3'd0};
        vecs[22] = '{1'b1, 5'h01, 14'h0ABC, 1'b0, 1'b0, 14'h0ABC, 1'b1, 1'b0, 1'b0, 3'd0};
        vecs[23] = '{1'b1, 5'h02, 14'h0DEF, 1'b1, 1'b0, 14'h0ABC, 1'b1, 1'b0, 1'b0, 3'd0};
        vecs[24] = '{1'b1, OP_LDM, 14'h0000, 1'b0, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[25] = '{1'b0, 5'h00, 14'h0000, 1'b0, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[26] = '{1'b0, 5'h00, 14'h0000, 1'b0, 1'b1, 14'h0000, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[27] = '{1'b1, OP_RET, 14'h0999, 1'b0, 1'b0, 14'h0999, 1'b1, 1'b0, 1'b1, 3'd2};
        vecs[28] = '{1'b1, 5'h01, 14'h0001, 1'b0, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b1, 3'd1};
        vecs[29] = '{1'b1, 5'h01, 14'h0002, 1'b0, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b0, 3'd0};

        rst_n       = 1'b0;
        instr_valid = 1'b0;
        opcode      = 5'h00;
        ctrl_in     = 14'h0000;
        stall       = 1'b0;
        flush       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 14'h0000, 1'b0, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 30; i++) begin
            apply(vecs[i].v, vecs[i].op, vecs[i].ci, vecs[i].st, vecs[i].fl);
            check($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_val,
                  vecs[i].e_imm, vecs[i].e_hold, vecs[i].e_cnt);
        end

        // Flush together with stall while two bubbles remain.
        apply(1'b1, OP_INT, 14'h0321, 1'b0, 1'b0);
        apply(1'b0, 5'h00, 14'h0000, 1'b0, 1'b0);
        check("int_cnt2", 14'h0000, 1'b0, 1'b0, 1'b1, 3'd2);
        apply(1'b0, 5'h00, 14'h0000, 1'b1, 1'b1);
        check("flush_stall_bubble", 14'h0000, 1'b0, 1'b0, 1'b0, 3'd0);

        // Asynchronous reset in the middle of a RET bubble run.
        apply(1'b1, OP_RET, 14'h0F0F, 1'b0, 1'b0);
        check("ret_issue", 14'h0F0F, 1'b1, 1'b0, 1'b1, 3'd2);
        apply(1'b0, 5'h00, 14'h0000, 1'b0, 1'b0);
        check("ret_cnt1", 14'h0000, 1'b0, 1'b0, 1'b1, 3'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 14'h0000, 1'b0, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b1, 5'h03, 14'h0444, 1'b0, 1'b0);
        check("after_reset", 14'h0444, 1'b1, 1'b0, 1'b0, 3'd0);
        apply(1'b0, 5'h00, 14'h0000, 1'b0, 1'b0);

        // Randomized traffic against a counting model.
        m_bub = 0;
        m_ldm = 1'b0;
        m_out = 14'h0000;
        m_val = 1'b0;
        m_imm = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            logic        v;
            logic [4:0]  op;
            logic [13:0] ci;
            logic        st;
            logic        fl;
            int          pick;
            v    = ($urandom_range(0, 9) < 7);
            pick = $urandom_range(0, 9);
            case (pick)
                0:       op = OP_LDM;
                1:       op = OP_RET;
                2:       op = OP_RTI;
                3:       op = OP_INT;
                default: op = 5'($urandom);
            endcase
            ci = 14'($urandom);
            st = ($urandom_range(0, 9) < 2);
            fl = ($urandom_range(0, 29) == 0);

            if (fl) begin
                m_bub = 0; m_ldm = 1'b0;
                m_out = 14'h0000; m_val = 1'b0; m_imm = 1'b0;
            end else if (st) begin
                m_bub = m_bub;
            end else if (m_bub > 0) begin
                m_bub = m_bub - 1;
                m_out = 14'h0000; m_val = 1'b0; m_imm = 1'b0;
            end else if (m_ldm) begin
                if (v) begin
                    m_ldm = 1'b0;
                    m_out = LDMC; m_val = 1'b1; m_imm = 1'b1;
                end else begin
                    m_out = 14'h0000; m_val = 1'b0; m_imm = 1'b0;
                end
            end else if (!v) begin
                m_out = 14'h0000; m_val = 1'b0; m_imm = 1'b0;
            end else if (op == OP_LDM) begin
                m_ldm = 1'b1;
                m_out = 14'h0000; m_val = 1'b0; m_imm = 1'b0;
            end else begin
                m_out = ci; m_val = 1'b1; m_imm = 1'b0;
                if (op == OP_RET || op == OP_RTI) m_bub = RET_B;
                else if (op == OP_INT) m_bub = INT_B;
                else m_bub = 0;
            end

            apply(v, op, ci, st, fl);
            check($sformatf("rand%0d", n), m_out, m_val, m_imm, (m_bub > 0), 3'(m_bub));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
